// File: rtl/pep_batch_scheduler.sv
// PBS slot (pid) allocator and batch launcher for the pep pipe.
// Pids are grouped into batches that launch on full, flush or timeout, and return to the pool once released downstream.
module pep_batch_scheduler #(
    parameter int TOTAL_PBS_NB   = 32,
    parameter int BATCH_PBS_NB   = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int PID_W          = $clog2(TOTAL_PBS_NB),
    parameter int BCNT_W         = $clog2(BATCH_PBS_NB + 1),
    parameter int FCNT_W         = $clog2(TOTAL_PBS_NB + 1)
) (
    input  logic                    clk,
    input  logic                    s_rst_n,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    output logic [PID_W-1:0]        cmd_pid,
    input  logic                    flush,
    input  logic                    free_vld,
    input  logic [PID_W-1:0]        free_pid,
    output logic                    batch_vld,
    input  logic                    batch_rdy,
    output logic [TOTAL_PBS_NB-1:0] batch_pid_mask,
    output logic [BCNT_W-1:0]       batch_pbs_nb,
    input  logic                    batch_done,
    output logic                    busy,
    output logic [FCNT_W-1:0]       free_cnt,
    output logic                    err_free,
    output logic [1:0]              state_dbg
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BATCH_PBS_NB);
    localparam logic [TOTAL_PBS_NB-1:0] ONE_BIT = TOTAL_PBS_NB'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [TOTAL_PBS_NB-1:0] alloc_map, pend_map, run_map;
    logic [TOTAL_PBS_NB-1:0] acc_bit, free_bit;
    logic [BCNT_W-1:0]       pend_cnt, pend_cnt_nxt;
    logic [TMR_W-1:0]        timer;
    logic                    flush_pend;
    logic                    found;
    logic                    accept, free_ok, launch, launch_cond, run_clear;

    always_comb begin
        cmd_pid = '0;
        found   = 1'b0;
        for (int i = 0; i < TOTAL_PBS_NB; i++) begin
            if (!found && !alloc_map[i]) begin
                cmd_pid = PID_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign cmd_rdy  = (free_cnt != '0) && (pend_cnt != BCNT_MAX);
    assign accept   = cmd_vld && cmd_rdy;
    assign acc_bit  = accept ? (ONE_BIT << cmd_pid) : '0;
    // Only a pid that is allocated and already back from the pipe may be released.
    assign free_ok  = free_vld && alloc_map[free_pid] && !pend_map[free_pid] && !run_map[free_pid];
    assign free_bit = free_ok ? (ONE_BIT << free_pid) : '0;

    assign launch_cond = (pend_cnt == BCNT_MAX) ||
                         ((pend_cnt != '0) && (flush_pend || (timer == TMR_MAX)));

    // batch handshake: batch_vld rises with the LAUNCH state and, together with
    // batch_pid_mask, stays stable until the cycle batch_rdy is seen high.
    always_ff @(posedge clk) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        launch         = 1'b0;
        run_clear      = 1'b0;
        batch_vld      = 1'b0;
        batch_pid_mask = '0;
        case (state)
            IDLE: begin
                if (launch_cond) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                batch_vld      = 1'b1;
                batch_pid_mask = run_map;
                if (batch_rdy) state_nxt = RUN;
            end
            RUN: begin
                if (batch_done) begin
                    run_clear = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    assign pend_cnt_nxt = launch ? BCNT_W'(accept) : pend_cnt + BCNT_W'(accept);

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            alloc_map    <= '0;
            pend_map     <= '0;
            run_map      <= '0;
            pend_cnt     <= '0;
            timer        <= '0;
            flush_pend   <= 1'b0;
            batch_pbs_nb <= '0;
            free_cnt     <= FCNT_W'(TOTAL_PBS_NB);
            err_free     <= 1'b0;
        end else begin
            alloc_map <= (alloc_map | acc_bit) & ~free_bit;
            pend_map  <= launch ? acc_bit : (pend_map | acc_bit);
            pend_cnt  <= pend_cnt_nxt;
            if (launch) begin
                run_map      <= pend_map;
                batch_pbs_nb <= pend_cnt;
            end else if (run_clear) begin
                run_map      <= '0;
            end
            // Timer measures how long the current non-empty pending batch has waited.
            if (launch || pend_cnt_nxt == '0) timer <= '0;
            else if (timer != TMR_MAX)        timer <= timer + TMR_W'(1);
            if (launch)                                    flush_pend <= 1'b0;
            else if (flush && (pend_cnt != '0 || accept)) flush_pend <= 1'b1;
            free_cnt <= free_cnt - FCNT_W'(accept) + FCNT_W'(free_ok);
            if (free_vld && !free_ok) err_free <= 1'b1;
        end
    end

endmodule

// File: doc/pep_batch_scheduler.md
Name: pep_batch_scheduler

Overview:
- Allocates PBS slot ids (pids) from a pool of TOTAL_PBS_NB entries.
- Groups allocated pids into batches of at most BATCH_PBS_NB and launches one batch at a time into the pe_pbs processing pipe (BATCH_NB = 1).
- Returns pids to the free pool when the downstream result consumer releases them.
- Sits between the instruction front-end and the pep batch pipeline. It is the only owner of pid allocation.

Parameters:
- TOTAL_PBS_NB, 32, number of pid slots; must be >= BATCH_PBS_NB.
- BATCH_PBS_NB, 16, maximum number of pids per batch.
- TIMEOUT_CYCLES, 64, cycles a non-empty pending batch waits before a forced launch; must be >= 1.
- PID_W, $clog2(TOTAL_PBS_NB), pid width.
- BCNT_W, $clog2(BATCH_PBS_NB+1), batch count width.
- FCNT_W, $clog2(TOTAL_PBS_NB+1), free count width.

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  synchronous active-low reset.
- cmd_vld  in  1  new PBS request.
- cmd_rdy  out  1  request can be accepted.
- cmd_pid  out  PID_W  pid allocated to the request; meaningful when cmd_vld && cmd_rdy.
- flush  in  1  pulse; launch the pending batch at the next opportunity.
- free_vld  in  1  release one pid.
- free_pid  in  PID_W  pid being released.
- batch_vld  out  1  batch launch request.
- batch_rdy  in  1  pipe accepts the batch.
- batch_pid_mask  out  TOTAL_PBS_NB  one-hot-per-pid membership of the launched batch.
- batch_pbs_nb  out  BCNT_W  popcount of batch_pid_mask.
- batch_done  in  1  pulse; in-flight batch finished.
- busy  out  1  a batch is in LAUNCH or RUN.
- free_cnt  out  FCNT_W  number of free pids.
- err_free  out  1  sticky: illegal free seen.

Behaviour:
- **State.** Three bitmaps of TOTAL_PBS_NB bits each:
  - alloc_map (pid allocated, not yet freed)
  - pend_map (allocated, in the accumulating batch)
  - run_map (in the launched batch)
  - pend_cnt counts the set bits of pend_map.
- **Reset.**
  - All maps = 0, pend_cnt = 0, timer = 0, flush_pend = 0, FSM = IDLE.
  - Outputs: cmd_rdy = 1, cmd_pid = 0, batch_vld = 0, batch_pid_mask = 0, batch_pbs_nb = 0, busy = 0, free_cnt = TOTAL_PBS_NB, err_free = 0.
  - A reset asserted mid-batch discards all state. No done or free is expected afterwards.
- **Allocation.**
  - cmd_rdy = (free_cnt != 0) && (pend_cnt != BATCH_PBS_NB).
  - cmd_pid = lowest index with alloc_map = 0, computed combinationally from registered state.
  - On accept, set alloc_map and pend_map bits for that pid and increment pend_cnt.
  - Accumulation continues in every FSM state, including while a batch runs.
- **Free.**
  - free_vld with alloc_map[free_pid] = 1 and pend_map/run_map bits = 0 clears alloc_map[free_pid] next cycle.
  - Any other free (unallocated, pending or in flight) is ignored and sets err_free.
  - Same-cycle accept and free: both apply, and free_cnt is unchanged.
  - A pid freed in cycle N is allocatable from cycle N+1, never in cycle N.
- **Timer.**
  - Resets to 0 whenever pend_cnt = 0 or on launch.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
- **Flush.**
  - flush with pend_cnt > 0, or with an accept in the same cycle, sets flush_pend.
  - flush_pend clears on launch.
  - flush with nothing pending and no accept is dropped.
- **FSM.**
  - **IDLE**
    - Launch condition: pend_cnt = BATCH_PBS_NB, or pend_cnt > 0 && (flush_pend || timer = TIMEOUT_CYCLES).
    - When the launch condition holds, go to LAUNCH next cycle.
    - On that transition: run_map ← pend_map, batch_pbs_nb ← pend_cnt, pend_map/pend_cnt/timer/flush_pend cleared.
    - A pid accepted in the transition cycle goes into the new pend_map.
  - **LAUNCH**
    - batch_vld = 1, batch_pid_mask = run_map; both held stable until batch_rdy.
    - On batch_vld && batch_rdy, go to RUN.
  - **RUN**
    - On batch_done, clear run_map and go to IDLE.
    - The next launch can occur in the following cycle at the earliest.
    - batch_done outside RUN is ignored.
  - busy = (state != IDLE). Launch latency from the triggering condition to batch_vld is 1 cycle.
- **Output timing.** free_cnt is registered and equals TOTAL_PBS_NB minus the popcount of alloc_map.

Test Plan:
- **Fill-to-launch.** Reset, then 16 back-to-back cmd accepts → cmd_pid 0..15; cmd_rdy low after the 16th; batch_vld next cycle with mask 0x0000FFFF, batch_pbs_nb = 16.
- **Timeout.** TIMEOUT_CYCLES = 64, 3 accepts then idle → batch_vld 65 cycles after the first accept, mask 0x7, batch_pbs_nb = 3.
- **Flush and accumulation during RUN.** 5 accepts, flush, batch_rdy held 0 for 10 cycles → mask 0x1F stable throughout. Hold RUN; 16 more accepts → pids 5..20. After batch_done, next batch launches with mask 0x001FFFE0.
- **Exhaustion and recycle.** All 32 pids allocated → cmd_rdy = 0, free_cnt = 0. free pid 7 (batch done) → free_cnt = 1 next cycle; next accept gets pid 7. Simultaneous free 3 and accept → free_cnt unchanged.
- **Illegal free.** free pid 9 while in run_map, then free unallocated pid 30 → err_free = 1 sticky; alloc_map unchanged.
- **Reset mid-RUN.** Assert s_rst_n = 0 for 1 cycle → all outputs return to reset values; first accept gets pid 0.
